// File: rtl/led_mode_ctrl_pkg.sv
// Shared game-phase encoding and LED display mode constants for the table-tennis sequencer.
// The helper maps a game phase to the one-hot display mode shown in that phase.
package led_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_RALLY = 2'd1,
        ST_SHOW  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [3:0] LED_SCORE = 4'b1000;
    localparam logic [3:0] LED_RIGHT = 4'b0100;
    localparam logic [3:0] LED_TRACK = 4'b0010;
    localparam logic [3:0] LED_BLINK = 4'b0001;

    function automatic logic [3:0] led_of(input state_t s);
        case (s)
            ST_SERVE: return LED_RIGHT;
            ST_RALLY: return LED_TRACK;
            ST_SHOW:  return LED_SCORE;
            ST_OVER:  return LED_BLINK;
            default:  return LED_RIGHT;
        endcase
    endfunction

endpackage

// File: rtl/led_mode_ctrl_hold.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
// Load takes effect on the next edge and has priority over the decrement; no backpressure.
module hold_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/led_mode_ctrl.sv
// Table-tennis game sequencer: tracks serve/rally/score-hold/game-over, scores and serve right.
// All outputs registered, one-cycle latency from event to outputs; events are pulses, no backpressure.
module led_mode_ctrl
    import led_mode_ctrl_pkg::*;
#(
    parameter int SCORE_HOLD = 100_000_000,
    parameter int WIN_POINTS = 11,
    parameter int SERVE_SWAP = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serve_go,
    input  logic       point,
    input  logic       point_to_a,
    input  logic       new_game,
    output logic [3:0] led_control,
    output logic [3:0] score,
    output logic       right,
    output logic [3:0] score_a,
    output logic [3:0] score_b,
    output logic       game_over
);

    localparam int HW = $clog2(SCORE_HOLD + 1);
    localparam int SW = (SERVE_SWAP > 1) ? $clog2(SERVE_SWAP) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(SCORE_HOLD - 1);
    localparam logic [SW-1:0] SWAP_LAST = SW'(SERVE_SWAP - 1);
    localparam logic [3:0]    WIN       = 4'(WIN_POINTS);

    state_t        state_q, state_d;
    logic [3:0]    led_q, score_q, score_d, sa_q, sa_d, sb_q, sb_d;
    logic          right_q, right_d, over_q;
    logic [SW-1:0] swap_q, swap_d;
    logic          hold_load, hold_done;
    logic [HW-1:0] hold_val;

    hold_timer #(.W(HW)) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hold_load),
        .load_val (hold_val),
        .done     (hold_done)
    );

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        right_d   = right_q;
        swap_d    = swap_q;
        hold_load = 1'b0;
        hold_val  = HOLD_LOAD;
        if (new_game) begin
            state_d   = ST_SERVE;
            score_d   = 4'd0;
            sa_d      = 4'd0;
            sb_d      = 4'd0;
            right_d   = 1'b1;
            swap_d    = '0;
            hold_load = 1'b1;
            hold_val  = '0;
        end else begin
            case (state_q)
                ST_SERVE: if (serve_go) state_d = ST_RALLY;
                ST_RALLY: begin
                    if (point) begin
                        state_d   = ST_SHOW;
                        hold_load = 1'b1;
                        if (point_to_a) begin
                            sa_d    = sa_q + 4'd1;
                            score_d = sa_q + 4'd1;
                        end else begin
                            sb_d    = sb_q + 4'd1;
                            score_d = sb_q + 4'd1;
                        end
                        // Serve right flips on the same edge the swap count wraps.
                        if (swap_q == SWAP_LAST) begin
                            swap_d  = '0;
                            right_d = ~right_q;
                        end else begin
                            swap_d  = swap_q + 1'b1;
                        end
                    end
                end
                ST_SHOW: if (hold_done) state_d = (score_q == WIN) ? ST_OVER : ST_SERVE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SERVE;
            led_q   <= LED_RIGHT;
            score_q <= 4'd0;
            sa_q    <= 4'd0;
            sb_q    <= 4'd0;
            right_q <= 1'b1;
            swap_q  <= '0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_of(state_d);
            score_q <= score_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            right_q <= right_d;
            swap_q  <= swap_d;
            over_q  <= (state_d == ST_OVER);
        end
    end

    assign led_control = led_q;
    assign score       = score_q;
    assign right       = right_q;
    assign score_a     = sa_q;
    assign score_b     = sb_q;
    assign game_over   = over_q;

endmodule
